// File: rtl/split_bus_pkg.sv
// Shared types and constants for the split-transaction bus arbiter.
package split_bus_pkg;

   localparam int NUM_INITIATORS = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RESUME  = 2'd2
   } arb_state_t;

   function automatic logic [NUM_INITIATORS-1:0] owner_onehot(input logic idx);
      logic [NUM_INITIATORS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/split_bus_arbiter_hold_timer.sv
// Per-transaction hold timer: counts cycles while enabled and flags the last
// permitted cycle. TIMEOUT of zero disables expiry.
module hold_timer #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [W-1:0] r_cnt;
   logic         w_at_limit;

   assign w_at_limit = (TIMEOUT > 0) && (r_cnt == W'(TIMEOUT - 1));
   assign o_expire   = i_enable && w_at_limit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !w_at_limit && (r_cnt != W'(TIMEOUT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-initiator bus arbiter with split-transaction support: releases the bus on
// split_start and re-grants the suspended initiator together with the target.
module split_bus_arbiter
   import split_bus_pkg::*;
#(
   parameter int TIMEOUT     = 256,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_INITIATORS-1:0] req,
   input  logic                      txn_done,
   input  logic                      split_start,
   input  logic                      split_req,
   output logic [NUM_INITIATORS-1:0] grant,
   output logic                      split_grant,
   output logic                      bus_owner,
   output logic                      split_pending,
   output logic                      split_owner,
   output logic                      timeout_err
);

   arb_state_t                r_state;
   logic [NUM_INITIATORS-1:0] r_grant;
   logic                      r_split_grant;
   logic                      r_bus_owner;
   logic                      r_split_pending;
   logic                      r_split_owner;
   logic                      r_timeout_err;
   logic                      r_rr_ptr;

   logic [NUM_INITIATORS-1:0] w_block;
   logic [NUM_INITIATORS-1:0] w_elig;
   logic                      w_pick;
   logic                      w_expire;

   // The suspended initiator may not take the bus until its split resumes.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_block = '0;
      if (r_split_pending) w_block[r_split_owner] = 1'b1;
      w_elig = req & ~w_block;
      if (w_elig == 2'b11) w_pick = ROUND_ROBIN ? r_rr_ptr : 1'b0;
      else                 w_pick = w_elig[1];
   end

   hold_timer #(.TIMEOUT(TIMEOUT)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (r_state == IDLE),
      .i_enable (r_state != IDLE),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_grant         <= '0;
         r_split_grant   <= 1'b0;
         r_bus_owner     <= 1'b0;
         r_split_pending <= 1'b0;
         r_split_owner   <= 1'b0;
         r_timeout_err   <= 1'b0;
         r_rr_ptr        <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (r_split_pending && split_req) begin
                  r_state       <= RESUME;
                  r_grant       <= owner_onehot(r_split_owner);
                  r_split_grant <= 1'b1;
                  r_bus_owner   <= r_split_owner;
               end else if (|w_elig) begin
                  r_state     <= GRANTED;
                  r_grant     <= owner_onehot(w_pick);
                  r_bus_owner <= w_pick;
               end
            end
            GRANTED: begin
               // split_start takes precedence over a coincident txn_done.
               if (split_start) begin
                  r_state         <= IDLE;
                  r_grant         <= '0;
                  r_split_pending <= 1'b1;
                  r_split_owner   <= r_bus_owner;
               end else if (txn_done || w_expire) begin
                  r_state       <= IDLE;
                  r_grant       <= '0;
                  r_rr_ptr      <= ~r_bus_owner;
                  r_timeout_err <= !txn_done;
               end
            end
            RESUME: begin
               if (txn_done || w_expire) begin
                  r_state         <= IDLE;
                  r_grant         <= '0;
                  r_split_grant   <= 1'b0;
                  r_split_pending <= 1'b0;
                  r_timeout_err   <= !txn_done;
               end
            end
            default: begin
               r_state       <= IDLE;
               r_grant       <= '0;
               r_split_grant <= 1'b0;
            end
         endcase
      end
   end

   assign grant         = r_grant;
   assign split_grant   = r_split_grant;
   assign bus_owner     = r_bus_owner;
   assign split_pending = r_split_pending;
   assign split_owner   = r_split_owner;
   assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter (TIMEOUT=8, round robin): single grant,
// contention, split/resume, split-vs-done collision, timeouts and reset.
module tb_split_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic       txn_done;
   logic       split_start;
   logic       split_req;
   logic [1:0] grant;
   logic       split_grant;
   logic       bus_owner;
   logic       split_pending;
   logic       split_owner;
   logic       timeout_err;

   int n_pass  = 0;
   int n_total = 0;

   split_bus_arbiter #(.TIMEOUT(8), .ROUND_ROBIN(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .txn_done      (txn_done),
      .split_start   (split_start),
      .split_req     (split_req),
      .grant         (grant),
      .split_grant   (split_grant),
      .bus_owner     (bus_owner),
      .split_pending (split_pending),
      .split_owner   (split_owner),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; txn_done = 1'b0; split_start = 1'b0; split_req = 1'b0;
      step(); step();
      check("rst_grant", {2'b0, grant}, 4'h0);
      check("rst_split_grant", {3'b0, split_grant}, 4'h0);
      check("rst_split_pending", {3'b0, split_pending}, 4'h0);
      check("rst_bus_owner", {3'b0, bus_owner}, 4'h0);
      check("rst_timeout_err", {3'b0, timeout_err}, 4'h0);
      rst = 1'b0;

      // Single request, req drop ignored, txn_done releases.
      req = 2'b01; step();
      check("single_grant", {2'b0, grant}, 4'h1);
      req = 2'b00; step();
      check("single_hold", {2'b0, grant}, 4'h1);
      txn_done = 1'b1; step(); txn_done = 1'b0;
      check("single_release", {2'b0, grant}, 4'h0);
      check("single_owner_kept", {3'b0, bus_owner}, 4'h0);

      // Contention after reset: pointer starts at 0, alternates.
      rst = 1'b1; step(); rst = 1'b0;
      req = 2'b11; step();
      check("rr_first", {2'b0, grant}, 4'h1);
      txn_done = 1'b1; step(); txn_done = 1'b0;
      check("rr_idle1", {2'b0, grant}, 4'h0);
      step();
      check("rr_second", {2'b0, grant}, 4'h2);
      check("rr_second_owner", {3'b0, bus_owner}, 4'h1);
      txn_done = 1'b1; step(); txn_done = 1'b0;
      check("rr_idle2", {2'b0, grant}, 4'h0);
      step();
      check("rr_third", {2'b0, grant}, 4'h1);
      txn_done = 1'b1; req = 2'b00; step(); txn_done = 1'b0;
      step();
      check("rr_done", {2'b0, grant}, 4'h0);

      // Split flow with initiator 0.
      req = 2'b01; step();
      check("split_g0", {2'b0, grant}, 4'h1);
      split_start = 1'b1; step(); split_start = 1'b0;
      check("split_rel_grant", {2'b0, grant}, 4'h0);
      check("split_rel_pending", {3'b0, split_pending}, 4'h1);
      check("split_rel_owner", {3'b0, split_owner}, 4'h0);
      req = 2'b11; step(); req = 2'b00;
      check("split_other_only", {2'b0, grant}, 4'h2);
      txn_done = 1'b1; step(); txn_done = 1'b0;
      check("split_other_done", {2'b0, grant}, 4'h0);
      check("split_still_pending", {3'b0, split_pending}, 4'h1);
      split_req = 1'b1; step(); split_req = 1'b0;
      check("resume_grant", {2'b0, grant}, 4'h1);
      check("resume_split_grant", {3'b0, split_grant}, 4'h1);
      split_start = 1'b1; step(); split_start = 1'b0;
      check("resume_nested_ignored", {1'b0, split_grant, grant}, 4'h5);
      txn_done = 1'b1; step(); txn_done = 1'b0;
      check("resume_done", {split_pending, split_grant, grant}, 4'h0);
      split_req = 1'b1; step(); split_req = 1'b0;
      check("stray_split_req", {split_pending, split_grant, grant}, 4'h0);

      // Collision: split_start wins over txn_done, owner is initiator 1.
      req = 2'b10; step(); req = 2'b00;
      check("coll_g1", {2'b0, grant}, 4'h2);
      split_start = 1'b1; txn_done = 1'b1; step(); split_start = 1'b0; txn_done = 1'b0;
      check("coll_grant", {2'b0, grant}, 4'h0);
      check("coll_pending", {3'b0, split_pending}, 4'h1);
      check("coll_owner", {3'b0, split_owner}, 4'h1);
      split_req = 1'b1; step(); split_req = 1'b0;
      check("coll_resume", {1'b0, split_grant, grant}, 4'h6);

      // Reset mid-RESUME clears everything; a later split_req does nothing.
      rst = 1'b1; step(); rst = 1'b0;
      check("midrst", {split_pending, split_grant, grant}, 4'h0);
      split_req = 1'b1; step(); step(); split_req = 1'b0;
      check("midrst_stray", {split_pending, split_grant, grant}, 4'h0);

      // Timeout in GRANTED: pulse and release 8 edges after the grant edge.
      req = 2'b01; step(); req = 2'b00;
      check("to_grant", {2'b0, grant}, 4'h1);
      for (int i = 0; i < 7; i++) begin
         step();
         check("to_wait", {1'b0, timeout_err, grant}, 4'h1);
      end
      step();
      check("to_pulse", {1'b0, timeout_err, grant}, 4'h4);
      step();
      check("to_pulse_end", {1'b0, timeout_err, grant}, 4'h0);

      // Timeout in RESUME also clears split_pending (pointer now at 1, only req 0).
      req = 2'b01; step(); req = 2'b00;
      split_start = 1'b1; step(); split_start = 1'b0;
      check("to_r_pending", {3'b0, split_pending}, 4'h1);
      split_req = 1'b1; step(); split_req = 1'b0;
      check("to_r_resume", {1'b0, split_grant, grant}, 4'h5);
      for (int i = 0; i < 7; i++) step();
      check("to_r_before", {timeout_err, split_grant, grant}, 4'h5);
      step();
      check("to_r_pulse", {timeout_err, split_grant, grant}, 4'h8);
      check("to_r_pending_clr", {3'b0, split_pending}, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/split_bus_arbiter.md
Name: split_bus_arbiter

Overview:
- Central arbiter for the serial bus, shared by two initiators and one split-capable target.
- Grants bus ownership to one initiator at a time and frees the bus when the target issues a split.
- Re-grants the bus to the suspended initiator and the target together when the target raises its split request.
- Drives split_grant/arbiter_grant toward the split target port; enforces a per-transaction hold timeout.

Parameters:
- TIMEOUT, 256, max cycles a grant may be held without txn_done; 0 disables the timeout.
- ROUND_ROBIN, 1, 1 = alternate priority between initiators; 0 = initiator 0 always wins ties.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  bus request per initiator; level, held until granted.
- txn_done  in  1  one-cycle pulse, current bus transaction complete.
- split_start  in  1  one-cycle pulse from target: split acknowledged, release the bus.
- split_req  in  1  target ready to resume split transaction; level.
- grant  out  2  one-hot initiator grant; registered.
- split_grant  out  1  grant to split target; registered.
- bus_owner  out  1  index of granted initiator; valid while any grant bit is high.
- split_pending  out  1  a split transaction is suspended.
- split_owner  out  1  initiator suspended by the split; valid while split_pending.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = 0, hold counter = 0. Reset mid-transaction drops every grant and clears any pending split. No state survives.
- States: IDLE, GRANTED, RESUME.
- IDLE, evaluated each cycle in this order:
  - split_pending && split_req → RESUME; next cycle grant[split_owner]=1 and split_grant=1.
  - Otherwise choose among eligible req bits. An initiator is ineligible while it is split_owner with split_pending. Tie-break: RR pointer if ROUND_ROBIN, else index 0. → GRANTED; grant bit high next cycle.
  - Otherwise stay IDLE.
- Grant latency: request sampled in IDLE; grant asserted on the following edge (1 cycle).
- GRANTED:
  - txn_done → grant cleared next cycle, → IDLE, RR pointer = other initiator.
  - split_start → grant cleared; split_pending=1, split_owner=bus_owner; → IDLE.
  - split_start and txn_done in the same cycle: split_start wins, txn_done ignored.
- RESUME:
  - txn_done → grant and split_grant cleared, split_pending=0, → IDLE.
  - split_start in RESUME is ignored; no nested split.
- Turnaround: at least one IDLE cycle with no grant between consecutive ownerships. A grant bit and split_grant never change to a different owner without passing through IDLE.
- Ignored inputs:
  - split_start in IDLE.
  - split_req while split_pending=0.
  - txn_done in IDLE.
  - req deassertion during GRANTED (owner must finish with txn_done).
- Timeout (TIMEOUT>0):
  - Counter clears on entry to GRANTED/RESUME and increments each cycle there.
  - When it reaches TIMEOUT-1 without txn_done or split_start: timeout_err pulses, all grants drop next cycle, → IDLE.
  - In RESUME the timeout also clears split_pending.
  - Counter width clog2(TIMEOUT+1); no wrap.
- Invariants: grant is one-hot or zero. split_grant=1 implies grant[split_owner]=1.

Decomposition:
- Package split_bus_pkg: state enum arb_state_t {IDLE, GRANTED, RESUME}; localparam NUM_INITIATORS=2.
- Sub-module hold_timer, parameterised by TIMEOUT: inputs clear/enable, output expire.
- Priority selection stays inline.

Test Plan:
- Single request: req=2'b01 after reset → grant=2'b01 one cycle later; txn_done → grant=0 next cycle, bus_owner held until then.
- Contention with ROUND_ROBIN=1: req=2'b11 held for 3 transactions → grants 01, 10, 01, each separated by one idle cycle.
- Split flow: initiator 0 granted, split_start → grant=0, split_pending=1, split_owner=0. req=2'b11 → grant=2'b10 only. txn_done, then split_req=1 → grant=2'b01 and split_grant=1. txn_done → all 0, split_pending=0.
- Simultaneous split_start and txn_done while initiator 1 owns the bus → split_pending=1, split_owner=1.
- Timeout with TIMEOUT=8: grant held with no txn_done → timeout_err pulse 8 cycles after the grant edge, grant=0 next cycle.
- Reset mid-RESUME: rst=1 for 1 cycle → grant=0, split_grant=0, split_pending=0 after that edge. Stray split_req afterwards → no grant.
